waveform_dm_cmd_ctrl: RTL and testbench

WAVEFORM_DM_CMD_CTRL -- requirements
Module: waveform_dm_cmd_ctrl

---
 rtl/waveform_dm_cmd_ctrl_pkg.sv | 39 +++
 rtl/waveform_dm_cmd_ctrl_if.sv | 23 ++
 rtl/waveform_dm_cmd_ctrl_dm_cmd_channel.sv | 124 ++++++++++++
 rtl/waveform_dm_cmd_ctrl.sv | 56 +++++
 tb/tb_waveform_dm_cmd_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/waveform_dm_cmd_ctrl_pkg.sv
// Shared definitions for the waveform datamover command controller.
// Holds the command/status field layout, channel FSM states and the status codes.
package waveform_dm_cmd_ctrl_pkg;
    localparam int CMD_W = 72;
    localparam int STS_W = 8;
    localparam int TAG_W = 4;
    localparam int BTT_W = 23;

    localparam int CMD_BTT_LSB  = 0;
    localparam int CMD_TYPE_BIT = 23;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_TAG_LSB  = 64;

    localparam int STS_OKAY_BIT = 7;
    localparam int STS_ERR_MSB  = 6;
    localparam int STS_ERR_LSB  = 4;
    localparam int STS_TAG_MSB  = 3;
    localparam int STS_TAG_LSB  = 0;

    localparam logic [STS_W-1:0] STS_TIMEOUT = 8'hFF;
    localparam logic [STS_W-1:0] STS_REJECT  = 8'h00;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_STS} state_e;

    // INCR burst with EOF set; reserved fields stay zero.
    function automatic logic [CMD_W-1:0] build_cmd(input logic [31:0] addr,
                                                   input logic [BTT_W-1:0] btt,
                                                   input logic [TAG_W-1:0] tag);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMD_BTT_LSB +: BTT_W] = btt;
        c[CMD_TYPE_BIT]         = 1'b1;
        c[CMD_EOF_BIT]          = 1'b1;
        c[CMD_ADDR_LSB +: 32]   = addr;
        c[CMD_TAG_LSB +: TAG_W] = tag;
        return c;
    endfunction
endpackage

// File: rtl/waveform_dm_cmd_ctrl_if.sv
// Datamover command + status stream pair for one channel.
// master = controller side, slave = datamover side.
interface waveform_dm_cmd_ctrl_if;
    import waveform_dm_cmd_ctrl_pkg::*;

    logic [CMD_W-1:0] cmd_tdata;
    logic             cmd_tvalid;
    logic             cmd_tready;
    logic [STS_W-1:0] sts_tdata;
    logic             sts_tkeep;
    logic             sts_tlast;
    logic             sts_tvalid;
    logic             sts_tready;

    modport master (
        output cmd_tdata, cmd_tvalid, sts_tready,
        input  cmd_tready, sts_tdata, sts_tkeep, sts_tlast, sts_tvalid
    );
    modport slave (
        input  cmd_tdata, cmd_tvalid, sts_tready,
        output cmd_tready, sts_tdata, sts_tkeep, sts_tlast, sts_tvalid
    );
endinterface

// File: rtl/waveform_dm_cmd_ctrl_dm_cmd_channel.sv
// One datamover channel: validates a request, issues the tagged command,
// then waits (bounded) for the matching status beat.
module dm_cmd_channel
    import waveform_dm_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535,
    parameter int BRAM_AW     = 18
) (
    input  logic                   clk_in1,
    input  logic                   aresetn,
    input  logic                   req,
    input  logic [31:0]            addr,
    input  logic [BTT_W-1:0]       btt,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   done,
    output logic [STS_W-1:0]       sts,
    output logic                   err,
    waveform_dm_cmd_ctrl_if.master dm
);
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    // Wide enough that neither the window offset nor btt itself can wrap.
    localparam int SUM_W = (BRAM_AW + 1 > BTT_W + 1) ? BRAM_AW + 1 : BTT_W + 1;

    state_e           state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [STS_W-1:0] sts_q, sts_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             err_set;

    logic [SUM_W-1:0] end_addr;
    logic             req_ok;
    logic             sts_bad;
    logic             unused_sts_side;

    assign end_addr = SUM_W'(addr[BRAM_AW-1:0]) + SUM_W'(btt);
    assign req_ok   = (btt != '0) && (addr[1:0] == 2'b00) && (addr[31:BRAM_AW] == '0)
                   && (end_addr <= (SUM_W'(1) << BRAM_AW));
    assign sts_bad  = !dm.sts_tdata[STS_OKAY_BIT]
                   || (dm.sts_tdata[STS_ERR_MSB:STS_ERR_LSB] != '0)
                   || (dm.sts_tdata[STS_TAG_MSB:STS_TAG_LSB] != cmd_q[CMD_TAG_LSB +: TAG_W]);
    assign unused_sts_side = &{1'b0, dm.sts_tkeep, dm.sts_tlast};

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        sts_d   = sts_q;
        done_d  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_ok) begin
                        cmd_d   = build_cmd(addr, btt, tag_q);
                        state_d = ST_CMD;
                    end else begin
                        err_set = 1'b1;
                        sts_d   = STS_REJECT;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (dm.cmd_tready) begin
                    state_d = ST_STS;
                    tag_d   = tag_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_STS: begin
                if (dm.sts_tvalid) begin
                    sts_d   = dm.sts_tdata;
                    err_set = sts_bad;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    sts_d   = STS_TIMEOUT;
                    err_set = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new error in the same cycle as err_clr keeps the flag set.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk_in1) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            sts_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            sts_q   <= sts_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dm.cmd_tdata  = cmd_q;
    assign dm.cmd_tvalid = (state_q == ST_CMD);
    assign dm.sts_tready = (state_q == ST_STS);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign sts           = sts_q;
    assign err           = err_q;
endmodule

// File: rtl/waveform_dm_cmd_ctrl.sv
// Waveform BRAM datamover command controller: independent S2MM (load) and
// MM2S (play) command/status channels sharing one clock and reset.
module waveform_dm_cmd_ctrl
    import waveform_dm_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65535,
    parameter int BRAM_AW     = 18
) (
    input  logic                   clk_in1,
    input  logic                   aresetn,
    input  logic                   wr_req,
    input  logic [31:0]            wr_addr,
    input  logic [BTT_W-1:0]       wr_btt,
    input  logic                   rd_req,
    input  logic [31:0]            rd_addr,
    input  logic [BTT_W-1:0]       rd_btt,
    input  logic                   err_clr,
    output logic                   wr_busy,
    output logic                   wr_done,
    output logic [STS_W-1:0]       wr_sts,
    output logic                   wr_err,
    output logic                   rd_busy,
    output logic                   rd_done,
    output logic [STS_W-1:0]       rd_sts,
    output logic                   rd_err,
    waveform_dm_cmd_ctrl_if.master s2mm,
    waveform_dm_cmd_ctrl_if.master mm2s
);
    dm_cmd_channel #(.TIMEOUT_CYC(TIMEOUT_CYC), .BRAM_AW(BRAM_AW)) u_s2mm (
        .clk_in1 (clk_in1),
        .aresetn (aresetn),
        .req     (wr_req),
        .addr    (wr_addr),
        .btt     (wr_btt),
        .err_clr (err_clr),
        .busy    (wr_busy),
        .done    (wr_done),
        .sts     (wr_sts),
        .err     (wr_err),
        .dm      (s2mm)
    );

    dm_cmd_channel #(.TIMEOUT_CYC(TIMEOUT_CYC), .BRAM_AW(BRAM_AW)) u_mm2s (
        .clk_in1 (clk_in1),
        .aresetn (aresetn),
        .req     (rd_req),
        .addr    (rd_addr),
        .btt     (rd_btt),
        .err_clr (err_clr),
        .busy    (rd_busy),
        .done    (rd_done),
        .sts     (rd_sts),
        .err     (rd_err),
        .dm      (mm2s)
    );
endmodule

// File: tb/tb_waveform_dm_cmd_ctrl.sv
// Scoreboard bench for waveform_dm_cmd_ctrl: stimulus pushes expected commands
// and completions, a negedge monitor pops and compares them.
module tb_waveform_dm_cmd_ctrl;
    logic        clk_in1 = 1'b0;
    logic        aresetn = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0, err_clr = 1'b0;
    logic [31:0] wr_addr = '0, rd_addr = '0;
    logic [22:0] wr_btt = '0, rd_btt = '0;
    logic        wr_busy, wr_done, wr_err, rd_busy, rd_done, rd_err;
    logic [7:0]  wr_sts, rd_sts;

    waveform_dm_cmd_ctrl_if wr_if ();
    waveform_dm_cmd_ctrl_if rd_if ();

    waveform_dm_cmd_ctrl #(.TIMEOUT_CYC(16), .BRAM_AW(18)) dut (
        .clk_in1 (clk_in1), .aresetn (aresetn),
        .wr_req  (wr_req),  .wr_addr (wr_addr), .wr_btt (wr_btt),
        .rd_req  (rd_req),  .rd_addr (rd_addr), .rd_btt (rd_btt),
        .err_clr (err_clr),
        .wr_busy (wr_busy), .wr_done (wr_done), .wr_sts (wr_sts), .wr_err (wr_err),
        .rd_busy (rd_busy), .rd_done (rd_done), .rd_sts (rd_sts), .rd_err (rd_err),
        .s2mm    (wr_if),   .mm2s    (rd_if)
    );

    always #5 clk_in1 = ~clk_in1;

    int checks = 0;
    int failures = 0;

    logic [71:0] exp_wr_cmd[$], exp_rd_cmd[$];
    logic [8:0]  exp_wr_done[$], exp_rd_done[$];
    logic [3:0]  wr_tag = '0, rd_tag = '0;
    logic        wr_errm = 1'b0, rd_errm = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in1);
            #1;
        end
    endtask

    function automatic logic [71:0] mk_cmd(input logic [31:0] a, input logic [22:0] b, input logic [3:0] t);
        return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, b};
    endfunction

    function automatic logic [25:0] out_vec();
        return {wr_busy, rd_busy, wr_done, rd_done, wr_err, rd_err, wr_sts, rd_sts,
                wr_if.cmd_tvalid, rd_if.cmd_tvalid, wr_if.sts_tready, rd_if.sts_tready};
    endfunction

    // Monitor: compare every command handshake and every done pulse.
    always @(negedge clk_in1) begin
        if (wr_if.cmd_tvalid && wr_if.cmd_tready) begin
            if (exp_wr_cmd.size() == 0) unexp("wr_cmd");
            else chk("wr_cmd", wr_if.cmd_tdata, exp_wr_cmd.pop_front());
        end
        if (rd_if.cmd_tvalid && rd_if.cmd_tready) begin
            if (exp_rd_cmd.size() == 0) unexp("rd_cmd");
            else chk("rd_cmd", rd_if.cmd_tdata, exp_rd_cmd.pop_front());
        end
        if (wr_done) begin
            if (exp_wr_done.size() == 0) unexp("wr_done");
            else chk("wr_done_sts_err", {wr_sts, wr_err}, exp_wr_done.pop_front());
        end
        if (rd_done) begin
            if (exp_rd_done.size() == 0) unexp("rd_done");
            else chk("rd_done_sts_err", {rd_sts, rd_err}, exp_rd_done.pop_front());
        end
    end

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        wr_errm = 1'b0;
        rd_errm = 1'b0;
    endtask

    // One full request on a channel (ch=1 is MM2S) with the given status reply.
    task automatic txn(input bit ch, input logic [31:0] a, input logic [22:0] b, input logic [7:0] sb);
        logic       ok, bad, em;
        logic [3:0] t;
        longint     end_a;
        int         n;
        end_a = longint'(a[17:0]) + longint'(b);
        ok = (b != 0) && (a[1:0] == 2'b00) && (a[31:18] == 0) && (end_a <= 64'h40000);
        t  = ch ? rd_tag : wr_tag;
        em = ch ? rd_errm : wr_errm;
        if (ok) begin
            bad = !(sb[7] && sb[6:4] == 3'b000 && sb[3:0] == t);
            em  = em | bad;
            if (ch) begin exp_rd_cmd.push_back(mk_cmd(a, b, t)); exp_rd_done.push_back({sb, em}); rd_tag = t + 4'd1; end
            else    begin exp_wr_cmd.push_back(mk_cmd(a, b, t)); exp_wr_done.push_back({sb, em}); wr_tag = t + 4'd1; end
        end else begin
            em = 1'b1;
            if (ch) exp_rd_done.push_back({8'h00, 1'b1});
            else    exp_wr_done.push_back({8'h00, 1'b1});
        end
        if (ch) begin rd_errm = em; rd_if.cmd_tready = 1'b1; rd_req = 1'b1; rd_addr = a; rd_btt = b; end
        else    begin wr_errm = em; wr_if.cmd_tready = 1'b1; wr_req = 1'b1; wr_addr = a; wr_btt = b; end
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        if (!ok) begin
            @(negedge clk_in1);
            chk(ch ? "rd_reject_done_lat" : "wr_reject_done_lat", ch ? rd_done : wr_done, 1);
            tick();
            return;
        end
        n = 0;
        while (!(ch ? rd_if.sts_tready : wr_if.sts_tready) && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            unexp(ch ? "rd_sts_wait_timeout" : "wr_sts_wait_timeout");
        end else begin
            if (ch) begin rd_if.sts_tdata = sb; rd_if.sts_tvalid = 1'b1; end
            else    begin wr_if.sts_tdata = sb; wr_if.sts_tvalid = 1'b1; end
            tick();
            wr_if.sts_tvalid = 1'b0;
            rd_if.sts_tvalid = 1'b0;
        end
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [71:0] exp;
        int n;
        wr_if.cmd_tready = 1'b0; wr_if.sts_tvalid = 1'b0; wr_if.sts_tdata = '0;
        wr_if.sts_tkeep = 1'b1;  wr_if.sts_tlast = 1'b1;
        rd_if.cmd_tready = 1'b0; rd_if.sts_tvalid = 1'b0; rd_if.sts_tdata = '0;
        rd_if.sts_tkeep = 1'b1;  rd_if.sts_tlast = 1'b1;

        tick(3);
        @(negedge clk_in1);
        chk("reset_outputs", out_vec(), 0);
        aresetn = 1'b1;
        tick(2);

        txn(0, 32'h100, 23'h400, 8'h80);      // basic load, tag 0
        txn(1, 32'h3FFFC, 23'h8, 8'h80);      // crosses window end -> reject
        txn(0, 32'h200, 23'h10, 8'hC1);       // SLVERR on tag 1
        tick(3);
        @(negedge clk_in1);
        chk("wr_err_sticky", wr_err, 1);
        tick();
        clear_err();
        @(negedge clk_in1);
        chk("err_cleared", {wr_err, rd_err}, 0);
        tick();
        txn(0, 32'h0, 23'h4, 8'h82);          // tag 2, clean
        txn(1, 32'h3FFF0, 23'h10, 8'h80);     // ends exactly at window top
        txn(1, 32'h1000, 23'h20, 8'h85);      // tag mismatch
        txn(0, 32'h102, 23'h4, 8'h80);        // misaligned
        txn(0, 32'h40000, 23'h4, 8'h80);      // above window
        txn(0, 32'h10, 23'h0, 8'h80);         // zero length
        clear_err();
        tick();

        // err_clr in the same cycle as a reject: error must survive
        exp_wr_done.push_back({8'h00, 1'b1});
        wr_req = 1'b1; wr_addr = 32'h2; wr_btt = 23'h4; err_clr = 1'b1;
        tick();
        wr_req = 1'b0; err_clr = 1'b0;
        @(negedge clk_in1);
        chk("set_wins_over_clr", wr_err, 1);
        tick();
        clear_err();
        tick();

        // Timeout: no status beat
        exp_wr_cmd.push_back(mk_cmd(32'h400, 23'h100, wr_tag));
        exp_wr_done.push_back({8'hFF, 1'b1});
        wr_tag = wr_tag + 4'd1;
        wr_if.cmd_tready = 1'b1;
        wr_req = 1'b1; wr_addr = 32'h400; wr_btt = 23'h100;
        tick();
        wr_req = 1'b0;
        tick();
        chk("sts_tready_in_sts", {wr_if.sts_tready, wr_busy}, 2'b11);
        n = 0;
        do begin
            tick();
            @(negedge clk_in1);
            n++;
        end while (!wr_done && n < 40);
        chk("timeout_latency", n, 16);
        tick(2);
        clear_err();
        tick();

        // Back-pressure on the command stream, with an ignored second request
        wr_if.cmd_tready = 1'b0;
        exp = mk_cmd(32'h800, 23'h40, wr_tag);
        exp_wr_cmd.push_back(exp);
        exp_wr_done.push_back({4'h8, wr_tag, 1'b0});
        wr_req = 1'b1; wr_addr = 32'h800; wr_btt = 23'h40;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in1);
            chk("stall_tvalid_busy", {wr_if.cmd_tvalid, wr_busy, wr_if.sts_tready}, 3'b110);
            chk("stall_tdata", wr_if.cmd_tdata, exp);
            if (i == 2) begin wr_req = 1'b1; wr_addr = 32'h1000; wr_btt = 23'h8; end
            tick();
            wr_req = 1'b0;
        end
        wr_if.cmd_tready = 1'b1;
        tick();
        wr_if.sts_tdata = {4'h8, wr_tag}; wr_if.sts_tvalid = 1'b1;
        wr_tag = wr_tag + 4'd1;
        tick();
        wr_if.sts_tvalid = 1'b0;
        tick(2);
        @(negedge clk_in1);
        chk("ignored_req_not_queued", {wr_busy, wr_if.cmd_tvalid}, 0);
        tick();

        // Both channels at once, then reset while both wait for status
        exp_wr_cmd.push_back(mk_cmd(32'h0, 23'h80, wr_tag));
        exp_rd_cmd.push_back(mk_cmd(32'h100, 23'h80, rd_tag));
        wr_if.cmd_tready = 1'b1; rd_if.cmd_tready = 1'b1;
        wr_req = 1'b1; wr_addr = 32'h0;   wr_btt = 23'h80;
        rd_req = 1'b1; rd_addr = 32'h100; rd_btt = 23'h80;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        chk("both_in_sts", {wr_if.sts_tready, rd_if.sts_tready}, 2'b11);
        aresetn = 1'b0;
        tick();
        @(negedge clk_in1);
        chk("midflight_reset_outputs", out_vec(), 0);
        tick();
        aresetn = 1'b1;
        wr_tag = '0; rd_tag = '0; wr_errm = 1'b0; rd_errm = 1'b0;
        tick(20);
        txn(0, 32'h0, 23'h8, 8'h80);          // tag restarts at 0
        txn(1, 32'h0, 23'h8, 8'h80);

        tick(2);
        chk("queues_drained", {exp_wr_cmd.size(), exp_rd_cmd.size(), exp_wr_done.size(), exp_rd_done.size()}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
